bcd_encoder: RTL and testbench



---
 rtl/bcd_encoder_if.sv | 11 +
 rtl/bcd_encoder.sv | 100 ++++++++++
 tb/tb_bcd_encoder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/bcd_encoder_if.sv
// Bus between a binary producer and the bcd_encoder.
// The master drives the value to convert; the slave returns the decimal digits and done.
interface bcd_encoder_if;
  logic [31:0] binary;
  logic [7:0]  length;
  logic [3:0]  BCD [7:0];
  logic        done;

  modport master (output binary, length, input BCD, done);
  modport slave  (input binary, length, output BCD, done);
endinterface

// File: rtl/bcd_encoder.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Restarts by itself whenever binary/length differ from the copy latched at LOAD.
module bcd_encoder (
  input  logic          clk,
  input  logic          rst,
  bcd_encoder_if.slave  bus
);
  typedef enum logic [1:0] {LOAD, SHIFT, DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] bin_reg, bin_next;
  logic [7:0]  len_reg, len_next;
  logic [5:0]  cnt_reg, cnt_next;
  logic [31:0] dig_reg, dig_next;
  logic [31:0] bcd_reg, bcd_next;
  logic        done_reg, done_next;

  logic [5:0]  n_clamped;
  logic [4:0]  bit_idx;
  logic [31:0] dig_adj;
  logic [31:0] dig_shift;

  assign n_clamped = (bus.length > 8'd32) ? 6'd32 : bus.length[5:0];
  // cnt_reg is 1..32 while shifting; 32 wraps to index 31 in five bits
  assign bit_idx   = cnt_reg[4:0] - 5'd1;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
      assign dig_adj[gi*4 +: 4] = (dig_reg[gi*4 +: 4] >= 4'd5) ?
                                  dig_reg[gi*4 +: 4] + 4'd3 : dig_reg[gi*4 +: 4];
      assign bus.BCD[gi] = bcd_reg[gi*4 +: 4];
    end
  endgenerate

  // The bit leaving digit 7 is a multiple of 10^8 and is dropped
  assign dig_shift = {dig_adj[30:0], bin_reg[bit_idx]};
  assign bus.done  = done_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= LOAD;
      bin_reg   <= '0;
      len_reg   <= '0;
      cnt_reg   <= '0;
      dig_reg   <= '0;
      bcd_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      bin_reg   <= bin_next;
      len_reg   <= len_next;
      cnt_reg   <= cnt_next;
      dig_reg   <= dig_next;
      bcd_reg   <= bcd_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    bin_next   = bin_reg;
    len_next   = len_reg;
    cnt_next   = cnt_reg;
    dig_next   = dig_reg;
    bcd_next   = bcd_reg;
    done_next  = done_reg;
    case (state_reg)
      LOAD: begin
        bin_next = bus.binary;
        len_next = bus.length;
        cnt_next = n_clamped;
        dig_next = '0;
        if (n_clamped != 6'd0) begin
          done_next  = 1'b0;
          state_next = SHIFT;
        end else begin
          bcd_next   = '0;
          done_next  = 1'b1;
          state_next = DONE;
        end
      end
      SHIFT: begin
        dig_next = dig_shift;
        cnt_next = cnt_reg - 6'd1;
        if (cnt_reg == 6'd1) begin
          bcd_next   = dig_shift;
          done_next  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if ((bus.binary != bin_reg) || (bus.length != len_reg)) begin
          done_next  = 1'b0;
          state_next = LOAD;
        end
      end
      default: state_next = LOAD;
    endcase
  end
endmodule

// File: tb/tb_bcd_encoder.sv
// Randomized self-checking bench for bcd_encoder against an arithmetic decimal model.
module tb_bcd_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_encoder_if bus();
  bcd_encoder dut (.clk(clk), .rst(rst), .bus(bus));

  int          n_vec = 0;
  int          n_miss = 0;
  logic [31:0] exp_prev = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_len(input logic [7:0] l);
    return (l > 8'd32) ? 32 : int'(l);
  endfunction

  // Decimal digits of the windowed value, modulo 10^8, packed units-first
  function automatic logic [31:0] ref_bcd(input logic [31:0] b, input logic [7:0] l);
    longint unsigned v;
    logic [31:0] r;
    int n;
    n = eff_len(l);
    v = (n == 0) ? 64'd0 : (64'(b) & ((64'd1 << n) - 64'd1));
    v = v % 64'd100000000;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(v % 64'd10);
      v = v / 64'd10;
    end
    return r;
  endfunction

  function automatic logic [31:0] bcd_now();
    logic [31:0] p;
    for (int i = 0; i < 8; i++) p[i*4 +: 4] = bus.BCD[i];
    return p;
  endfunction

  function automatic logic [31:0] digits_ok();
    logic [31:0] p;
    p = bcd_now();
    for (int i = 0; i < 8; i++) if (p[i*4 +: 4] > 4'd9) return 32'd0;
    return 32'd1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive new inputs; from DONE the next edge must drop done and keep the old digits
  task automatic start(input logic [31:0] b, input logic [7:0] l, input bit from_load);
    bus.binary = b;
    bus.length = l;
    if (!from_load) begin
      tick();
      check("clear_done", 32'(bus.done), 32'd0);
      check("held_bcd", bcd_now(), exp_prev);
    end
  endtask

  task automatic finish(input logic [31:0] b, input logic [7:0] l, input int e0);
    int k;
    logic [31:0] exp;
    k = 0;
    exp = ref_bcd(b, l);
    while (!bus.done && k < 40) begin
      tick();
      k++;
    end
    check("latency", 32'(k), 32'(eff_len(l) + 1 - e0));
    check("result", bcd_now(), exp);
    check("digit_range", digits_ok(), 32'd1);
    exp_prev = exp;
    $display("vec bin=%0d len=%0d bcd=%08h edges=%0d", b, l, bcd_now(), k + e0);
  endtask

  task automatic convert(input logic [31:0] b, input logic [7:0] l, input bit from_load);
    start(b, l, from_load);
    finish(b, l, 0);
  endtask

  initial begin
    int changes;
    logic [31:0] snap, rb;
    logic [7:0] rl;

    bus.binary = $urandom;
    bus.length = 8'd20;
    tick();
    tick();
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_bcd", bcd_now(), 32'd0);
    rst = 1'b0;

    convert(32'd162, 8'd8, 1'b1);
    changes = 0;
    snap = bcd_now();
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bcd_now() !== snap || bus.done !== 1'b1) changes++;
    end
    check("hold_stable", 32'(changes), 32'd0);

    convert(32'd12345678, 8'd24, 1'b0);
    convert(32'hFFFF_FFFF, 8'd32, 1'b0);
    convert($urandom, 8'd0, 1'b0);
    convert(32'd99999999, 8'd40, 1'b0);

    // Mid-conversion input change: old value completes, done pulses, then new value
    start(32'd9876543, 8'd24, 1'b0);
    repeat (5) tick();
    bus.binary = 32'd1234567;
    finish(32'd9876543, 8'd24, 5);
    convert(32'd1234567, 8'd24, 1'b0);

    // Reset mid-conversion discards everything
    start(32'h00AB_CDEF, 8'd24, 1'b0);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_bcd", bcd_now(), 32'd0);
    rst = 1'b0;
    exp_prev = '0;
    convert(32'd4096, 8'd13, 1'b1);

    for (int i = 0; i < 30; i++) begin
      rb = $urandom;
      rl = 8'($urandom_range(0, 40));
      if (rb == bus.binary && rl == bus.length) rb = rb ^ 32'd1;
      convert(rb, rl, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
